// File: rtl/tone_cal_sequencer.sv
// tone_cal_sequencer
//   Front-end scheduler for the single-tone channel-correction chain.
//   On start it walks NUM_CH channels in order. For each channel it streams
//   FRAME_LEN samples from the capture BRAM into the chain. It then waits for
//   the chain's phase/amplitude result and emits it tagged with the channel
//   index. A channel whose result does not arrive within TIMEOUT cycles is
//   flagged in err_mask, and its result is written as zeros.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   start, abort              run control (start is a pulse; abort is a level or pulse)
//   proc_ready                chain can take samples
//   bram_rd_en/addr/data      capture BRAM read port (data RD_LAT edges after en)
//   tone_signal(_valid)       sample stream to the chain
//   channel_phase/amplitude/
//   channel_data_valid        result from the chain
//   cal_wr/ch/phase/amplitude result write-out
//   busy, done, err_mask      run status
//
// Read-latency alignment: bram_rd_data for a read issued in cycle t must be
// present at the RD_LAT-th clock edge after t (the BRAM holds RD_LAT-1
// register stages). This block supplies the last capture register, so
// tone_signal and tone_signal_valid appear together RD_LAT cycles after
// the read.
module tone_cal_sequencer #(
  parameter int NUM_CH    = 4,
  parameter int FRAME_LEN = 256,
  parameter int ADDR_W    = 10,
  parameter int RD_LAT    = 2,
  parameter int TIMEOUT   = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     proc_ready,
  output logic                     bram_rd_en,
  output logic [ADDR_W-1:0]        bram_rd_addr,
  input  logic signed [11:0]       bram_rd_data,
  output logic signed [11:0]       tone_signal,
  output logic                     tone_signal_valid,
  input  logic signed [11:0]       channel_phase,
  input  logic signed [11:0]       channel_amplitude,
  input  logic                     channel_data_valid,
  output logic                     cal_wr,
  output logic [7:0]               cal_ch,
  output logic signed [11:0]       cal_phase,
  output logic signed [11:0]       cal_amplitude,
  output logic                     busy,
  output logic                     done,
  output logic [NUM_CH-1:0]        err_mask
);

  localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TO_W  = $clog2(TIMEOUT);

  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(FRAME_LEN - 1);
  localparam logic [CH_W-1:0]  CH_LAST    = CH_W'(NUM_CH - 1);
  localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT - 1);
  localparam logic [2:0]       DRAIN_LAST = 3'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WAIT, S_STORE, S_DONE
  } state_e;

  state_e                    state_q, state_d;
  logic [CH_W-1:0]           ch_q, ch_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic                      rd_done_q, rd_done_d;   // last read of the frame issued
  logic [2:0]                drain_q, drain_d;       // cycles since the last read
  logic [TO_W-1:0]           to_cnt_q, to_cnt_d;
  logic [NUM_CH-1:0]         err_q, err_d;
  logic signed [11:0]        ph_q, ph_d;
  logic signed [11:0]        amp_q, amp_d;
  logic [7:0]                cal_ch_q, cal_ch_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      cal_wr_q, cal_wr_d;
  logic                      rd_issue;
  logic [RD_LAT:1]           vld_q;                  // rd_issue delayed 1..RD_LAT
  logic                      vld_tap;
  logic signed [11:0]        tone_q;

  // Next-state / output decode. abort outranks everything outside IDLE, so a
  // coincident result, timeout or read is simply dropped.
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    rd_done_d = rd_done_q;
    drain_d   = drain_q;
    to_cnt_d  = to_cnt_q;
    err_d     = err_q;
    ph_d      = ph_q;
    amp_d     = amp_q;
    cal_ch_d  = cal_ch_q;
    rd_issue  = 1'b0;

    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            state_d   = S_READ;
            ch_d      = '0;
            idx_d     = '0;
            addr_d    = '0;
            rd_done_d = 1'b0;
            drain_d   = '0;
            err_d     = '0;
          end
        end
        S_READ: begin
          if (!rd_done_q) begin
            if (proc_ready) begin
              rd_issue = 1'b1;
              addr_d   = addr_q + ADDR_W'(1);
              if (idx_q == IDX_LAST) begin
                rd_done_d = 1'b1;
                drain_d   = '0;
              end else begin
                idx_d = idx_q + IDX_W'(1);
              end
            end
          end else if (drain_q == DRAIN_LAST) begin
            // last sample is on tone_signal this cycle
            state_d  = S_WAIT;
            to_cnt_d = '0;
          end else begin
            drain_d = drain_q + 3'd1;
          end
        end
        S_WAIT: begin
          cal_ch_d = 8'(ch_q);
          if (channel_data_valid) begin
            ph_d    = channel_phase;
            amp_d   = channel_amplitude;
            state_d = S_STORE;
          end else if (to_cnt_q == TO_LAST) begin
            err_d[ch_q] = 1'b1;
            ph_d        = '0;
            amp_d       = '0;
            state_d     = S_STORE;
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
        S_STORE: begin
          if (ch_q == CH_LAST) begin
            state_d = S_DONE;
          end else begin
            // addr_q already sits at (ch+1)*FRAME_LEN after the last read
            ch_d      = ch_q + CH_W'(1);
            idx_d     = '0;
            rd_done_d = 1'b0;
            drain_d   = '0;
            state_d   = S_READ;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    busy_d   = (state_d == S_READ) || (state_d == S_WAIT) || (state_d == S_STORE);
    done_d   = (state_d == S_DONE);
    cal_wr_d = (state_d == S_STORE);
  end

  // Tap where bram_rd_data for the oldest in-flight read is present.
  if (RD_LAT == 1) begin : g_tap1
    assign vld_tap = rd_issue;
  end else begin : g_tapn
    assign vld_tap = vld_q[RD_LAT-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ch_q      <= '0;
      idx_q     <= '0;
      addr_q    <= '0;
      rd_done_q <= 1'b0;
      drain_q   <= '0;
      to_cnt_q  <= '0;
      err_q     <= '0;
      ph_q      <= '0;
      amp_q     <= '0;
      cal_ch_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cal_wr_q  <= 1'b0;
      vld_q     <= '0;
      tone_q    <= '0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      rd_done_q <= rd_done_d;
      drain_q   <= drain_d;
      to_cnt_q  <= to_cnt_d;
      err_q     <= err_d;
      ph_q      <= ph_d;
      amp_q     <= amp_d;
      cal_ch_q  <= cal_ch_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cal_wr_q  <= cal_wr_d;
      if (abort) begin
        vld_q <= '0;                         // flush samples still in flight
      end else begin
        vld_q[1] <= rd_issue;
        for (int k = 2; k <= RD_LAT; k++) vld_q[k] <= vld_q[k-1];
      end
      if (vld_tap && !abort) tone_q <= bram_rd_data;
    end
  end

  // rd_en follows proc_ready and abort in the same cycle; everything else is registered.
  assign bram_rd_en        = rd_issue;
  assign bram_rd_addr      = addr_q;
  assign tone_signal       = tone_q;
  assign tone_signal_valid = vld_q[RD_LAT];
  assign cal_wr            = cal_wr_q;
  assign cal_ch            = cal_ch_q;
  assign cal_phase         = ph_q;
  assign cal_amplitude     = amp_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign err_mask          = err_q;

endmodule

// File: tb/tb_tone_cal_sequencer.sv
// Bench for tone_cal_sequencer: table of whole-run scenarios with expected
// results, plus hand-written abort / start+abort / async-reset sequences.
// A negedge monitor checks every sample and every result write on the fly.
module tb_tone_cal_sequencer;
  localparam int NC = 4;
  localparam int FL = 256;
  localparam int AW = 10;
  localparam int RL = 2;
  localparam int TO = 4096;
  localparam int BOUND = NC * (3 * FL + TO + 300);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              proc_ready = 1'b1;
  logic              bram_rd_en;
  logic [AW-1:0]     bram_rd_addr;
  logic signed [11:0] bram_rd_data = '0;
  logic signed [11:0] tone_signal;
  logic              tone_signal_valid;
  logic signed [11:0] channel_phase = '0;
  logic signed [11:0] channel_amplitude = '0;
  logic              channel_data_valid = 1'b0;
  logic              cal_wr;
  logic [7:0]        cal_ch;
  logic signed [11:0] cal_phase;
  logic signed [11:0] cal_amplitude;
  logic              busy;
  logic              done;
  logic [NC-1:0]     err_mask;

  tone_cal_sequencer #(.NUM_CH(NC), .FRAME_LEN(FL), .ADDR_W(AW), .RD_LAT(RL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .proc_ready(proc_ready),
    .bram_rd_en(bram_rd_en), .bram_rd_addr(bram_rd_addr), .bram_rd_data(bram_rd_data),
    .tone_signal(tone_signal), .tone_signal_valid(tone_signal_valid),
    .channel_phase(channel_phase), .channel_amplitude(channel_amplitude),
    .channel_data_valid(channel_data_valid),
    .cal_wr(cal_wr), .cal_ch(cal_ch), .cal_phase(cal_phase), .cal_amplitude(cal_amplitude),
    .busy(busy), .done(done), .err_mask(err_mask));

  always #5 clk = ~clk;

  // One run scenario: result delay, channels that never answer, ready toggling,
  // spurious result offset (0 = none), channel answering exactly on the timeout
  // cycle (-1 = none), stray start offset while busy (0 = none), expected err_mask.
  typedef struct {
    int       dly;
    logic [3:0] miss;
    bit       tog;
    int       spur;
    int       coin;
    int       restart;
    logic [3:0] exp_err;
  } run_t;

  run_t vec[4];
  run_t cfg;

  int total = 0, bad = 0;
  int cyc = 0, run_start = 0, spur_abs = -1;
  int vcnt = 0, wr_cnt = 0, done_cnt = 0;
  int timer = -1, tch = 0, lastv = 0;

  task automatic chk(input string nm, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic logic signed [11:0] mval(input int a);
    return 12'(a * 37 + 11);           // odd multiplier: distinct for every address
  endfunction
  function automatic logic signed [11:0] ph_of(input int c);
    return 12'(c * 100 + 7);
  endfunction
  function automatic logic signed [11:0] amp_of(input int c);
    return 12'(-(c * 50 + 3));
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Capture BRAM with one output register (RL-1 stages).
  always @(posedge clk) if (bram_rd_en) bram_rd_data <= mval(int'(bram_rd_addr));

  always @(negedge clk) proc_ready = cfg.tog ? 1'($urandom_range(0, 1)) : 1'b1;

  // Chain model + monitor.
  always @(negedge clk) begin
    channel_data_valid = 1'b0;
    if (spur_abs >= 0 && cyc == spur_abs) begin
      channel_data_valid = 1'b1;
      channel_phase      = 12'sh7FF;
      channel_amplitude  = 12'sh7FF;
    end
    if (timer > 0) timer--;
    else if (timer == 0) begin
      channel_data_valid = 1'b1;
      channel_phase      = ph_of(tch);
      channel_amplitude  = amp_of(tch);
      timer = -1;
    end
    if (tone_signal_valid) begin
      if (vcnt == 0 && !cfg.tog) chk("first_valid_lat", cyc - run_start, 1 + RL);
      chk("sample_data", tone_signal, mval(vcnt));
      vcnt++;
      if (vcnt % FL == 0) begin
        tch   = vcnt / FL - 1;
        lastv = cyc;
        if (tch < NC && !cfg.miss[tch]) timer = (tch == cfg.coin) ? TO - 1 : cfg.dly;
      end
    end
    if (cal_wr) begin
      if (wr_cnt < NC) begin
        chk("cal_ch", cal_ch, wr_cnt);
        chk("valids_before_wr", vcnt, FL * (wr_cnt + 1));
        chk("wr_latency", cyc - lastv,
            (cfg.miss[wr_cnt] || wr_cnt == cfg.coin) ? TO + 1 : cfg.dly + 2);
        chk("cal_phase", cal_phase, cfg.miss[wr_cnt] ? 0 : ph_of(wr_cnt));
        chk("cal_amplitude", cal_amplitude, cfg.miss[wr_cnt] ? 0 : amp_of(wr_cnt));
        chk("err_bit", err_mask[wr_cnt], cfg.miss[wr_cnt]);
      end
      wr_cnt++;
    end
    if (done) done_cnt++;
  end

  task automatic kick();
    vcnt = 0; wr_cnt = 0; done_cnt = 0; timer = -1; spur_abs = -1;
    @(posedge clk); #1 start = 1'b1;
    run_start = cyc;
    if (cfg.spur > 0) spur_abs = cyc + cfg.spur;
    @(posedge clk); #1 start = 1'b0;
    chk("busy_rise", busy, 1);
    if (!cfg.tog) begin
      chk("first_rd_en", bram_rd_en, 1);
      chk("first_rd_addr", bram_rd_addr, 0);
    end
  endtask

  task automatic run_one(input int vi);
    bit got;
    cfg = vec[vi];
    kick();
    got = 1'b0;
    for (int n = 0; n < BOUND && !got; n++) begin
      @(posedge clk); #1;
      start = (cfg.restart > 0 && cyc == run_start + cfg.restart);
      got = (done_cnt > 0);
    end
    start = 1'b0;
    chk("done_seen", got, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("done_once", done_cnt, 1);
    chk("wr_count", wr_cnt, NC);
    chk("valid_total", vcnt, NC * FL);
    chk("err_mask", err_mask, cfg.exp_err);
    chk("busy_after", busy, 0);
  endtask

  initial begin
    bit found;
    int vsave;
    vec[0] = '{100, 4'b0000, 1'b0, 0,  -1, 0,   4'b0000};
    vec[1] = '{20,  4'b0000, 1'b1, 0,  -1, 300, 4'b0000};
    vec[2] = '{30,  4'b0100, 1'b0, 0,  -1, 0,   4'b0100};
    vec[3] = '{40,  4'b0000, 1'b0, 50, 1,  0,   4'b0000};
    cfg = vec[0];

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cal_wr", cal_wr, 0);
    chk("rst_valid", tone_signal_valid, 0);
    chk("rst_err", err_mask, 0);
    chk("rst_rd_en", bram_rd_en, 0);
    chk("rst_addr", bram_rd_addr, 0);
    @(negedge clk) rst = 1'b0;

    for (int v = 0; v < 4; v++) run_one(v);

    // abort at idx 128 of ch1
    cfg = vec[0];
    kick();
    found = 1'b0;
    for (int n = 0; n < BOUND && !found; n++) begin
      @(posedge clk); #1;
      found = bram_rd_en && (bram_rd_addr == AW'(FL + 128));
    end
    chk("abort_point_reached", found, 1);
    abort = 1'b1;
    #1 chk("abort_rd_en_gate", bram_rd_en, 0);
    @(posedge clk); #1 abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", tone_signal_valid, 0);
    vsave = vcnt;
    repeat (10) @(posedge clk);
    #1;
    chk("abort_no_more_valids", vcnt, vsave);
    chk("abort_wr_count", wr_cnt, 1);
    chk("abort_no_done", done_cnt, 0);

    // start and abort together in IDLE: stays idle
    @(posedge clk); #1 start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", busy, 0);
    chk("start_abort_rd_en", bram_rd_en, 0);

    run_one(0);

    // async reset in the middle of WAIT for ch0
    cfg = vec[0];
    kick();
    found = 1'b0;
    for (int n = 0; n < BOUND && !found; n++) begin
      @(posedge clk); found = (vcnt >= FL);
    end
    chk("wait_reached", found, 1);
    repeat (20) @(posedge clk);
    #3 timer = -1; rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_phase", cal_phase, 0);
    chk("arst_addr", bram_rd_addr, 0);
    chk("arst_err", err_mask, 0);
    chk("arst_valid", tone_signal_valid, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_one(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
